smg_scan_ctrl: RTL and testbench

Display scan engine directly downstream of the smg_ip AXI-lite register file. It accepts frames of six 4-bit hex digits plus decimal-point and blank masks through a valid/ready handshake. Each frame is held in a shadow buffer and applied only at frame boundaries, so the display never tears. The block time-multiplexes the six-digit common-anode display and drives SMG_Data/Scan_Sig at the board pins.

---
 rtl/smg_pkg.sv | 25 ++
 rtl/smg_hex_decode.sv | 16 +
 rtl/smg_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_smg_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared constants and types for the seven-segment scan engine.
package smg_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [5:0] SCAN_OFF = 6'h3F;

  // Active-low {dp,g,f,e,d,c,b,a} patterns; entry n is the glyph for hex n.
  // dp (bit 7) is high in every entry and is overridden by the decoder.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // One complete display frame as offered by the register file.
  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  blank;
  } smg_frame_t;

  localparam smg_frame_t FRAME_CLEAR = '0;

endpackage

// File: rtl/smg_hex_decode.sv
// Combinational hex digit to active-low segment decoder with decimal point.
module smg_hex_decode
  import smg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  output logic [7:0] seg
);

  // Table lookup for the glyph, dp segment lit (low) when dp is requested.
  always_comb begin
    seg    = SEG_TABLE[digit];
    seg[7] = ~dp;
  end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Six-digit common-anode scan engine with shadowed frame updates.
// A frame offered through upd_valid/upd_ready lands in a pending buffer and
// is promoted to the active buffer only at a frame boundary (or at once
// while scanning is disabled), so a frame is never shown half old/half new.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        en,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [23:0] upd_digits,
  input  logic [5:0]  upd_dp,
  input  logic [5:0]  upd_blank,
  output logic        frame_done,
  output logic [7:0]  SMG_Data,
  output logic [5:0]  Scan_Sig
);

  localparam int             PW          = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [PW-1:0]  PRESC_LAST  = PW'(DIGIT_CYCLES - 1);
  localparam logic [PW-1:0]  PRESC_BLANK = PW'(BLANK_CYCLES);
  localparam logic [2:0]     IDX_LAST    = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  smg_frame_t    active_q, active_d;
  smg_frame_t    pending_q, pending_d;
  logic          done_q, done_d;
  logic [7:0]    seg_q, seg_d;
  logic [5:0]    scan_q, scan_d;

  logic          slot_wrap;
  logic          frame_bnd;
  logic          accept;

  logic [3:0]    digit_nib [NUM_DIGITS];
  logic [3:0]    cur_digit;
  logic          cur_dp;
  logic          cur_blank;
  logic [7:0]    cur_seg;

  // Split the active frame's packed digit field into per-digit nibbles.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign digit_nib[gi] = active_q.digits[4*gi +: 4];
    end
  endgenerate

  // Pick the digit currently being scanned out of the active frame.
  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_digit = digit_nib[i];
        cur_dp    = active_q.dp[i];
        cur_blank = active_q.blank[i];
      end
    end
  end

  smg_hex_decode u_dec (
    .digit (cur_digit),
    .dp    (cur_dp),
    .seg   (cur_seg)
  );

  // Prescaler / digit index sequencing; both park at zero while disabled.
  always_comb begin
    slot_wrap = (presc_q == PRESC_LAST);
    frame_bnd = en && slot_wrap && (idx_q == IDX_LAST);
    presc_d   = '0;
    idx_d     = '0;
    if (en) begin
      if (slot_wrap) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end else begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
      end
    end
  end

  // Handshake and shadow buffering. Accept and promote can never coincide:
  // accept needs the pending flag clear, promotion needs it set, so a frame
  // accepted on a boundary cycle waits for the following boundary.
  always_comb begin
    accept    = upd_valid && !pend_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    done_d    = frame_bnd;
    if (pend_q && (frame_bnd || !en)) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end
    if (accept) begin
      pending_d = '{digits: upd_digits, dp: upd_dp, blank: upd_blank};
      pend_d    = 1'b1;
    end
  end

  // Next pin values from the current scan position; dark during the
  // ghost-suppression interval at the start of each slot and when disabled.
  always_comb begin
    seg_d  = SEG_OFF;
    scan_d = SCAN_OFF;
    if (en && (presc_q >= PRESC_BLANK)) begin
      scan_d = SCAN_OFF & ~(6'd1 << idx_q);
      if (!cur_blank) begin
        seg_d = cur_seg;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      active_q  <= FRAME_CLEAR;
      pending_q <= FRAME_CLEAR;
      done_q    <= 1'b0;
      seg_q     <= SEG_OFF;
      scan_q    <= SCAN_OFF;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      seg_q     <= seg_d;
      scan_q    <= scan_d;
    end
  end

  assign upd_ready  = ~pend_q;
  assign frame_done = done_q;
  assign SMG_Data   = seg_q;
  assign Scan_Sig   = scan_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Randomized bench for smg_scan_ctrl against a time-based display model.
module tb_smg_scan_ctrl;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = DC * 6;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [23:0] upd_digits = '0;
  logic [5:0]  upd_dp = '0;
  logic [5:0]  upd_blank = '0;
  logic        frame_done;
  logic [7:0]  SMG_Data;
  logic [5:0]  Scan_Sig;

  smg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .en           (en),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_digits   (upd_digits),
    .upd_dp       (upd_dp),
    .upd_blank    (upd_blank),
    .frame_done   (frame_done),
    .SMG_Data     (SMG_Data),
    .Scan_Sig     (Scan_Sig)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: time since scanning (re)started, plus the two frame buffers.
  int          m_t = 0;
  logic        m_pend = 1'b0;
  logic [23:0] m_dig = '0, p_dig = '0;
  logic [5:0]  m_dp = '0, p_dp = '0;
  logic [5:0]  m_blank = '0, p_blank = '0;
  logic        last_acc = 1'b0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [5:0]  exp_scan = 6'h3F;
  logic        exp_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_pend = 1'b0; last_acc = 1'b0;
    m_dig = '0; m_dp = '0; m_blank = '0;
    p_dig = '0; p_dp = '0; p_blank = '0;
    exp_seg = 8'hFF; exp_scan = 6'h3F; exp_done = 1'b0;
  endtask

  // What the pins show after this clock edge, and how the buffers evolve.
  task automatic model_edge();
    int  slot, phase;
    logic bnd, acc;
    logic [7:0] glyph;
    if (rst) begin
      model_reset();
      return;
    end
    phase = m_t % DC;
    slot  = (m_t / DC) % 6;
    if (!en || phase < BC) begin
      exp_seg  = 8'hFF;
      exp_scan = 6'h3F;
    end else begin
      exp_scan = 6'h3F & ~(6'd1 << slot);
      glyph    = HEX[m_dig[slot*4 +: 4]];
      exp_seg  = m_blank[slot] ? 8'hFF : {~m_dp[slot], glyph[6:0]};
    end
    bnd      = en && (m_t % FRAME == FRAME - 1);
    exp_done = bnd;
    acc      = upd_valid && !m_pend;
    last_acc = acc;
    if (m_pend && (bnd || !en)) begin
      m_dig = p_dig; m_dp = p_dp; m_blank = p_blank;
      m_pend = 1'b0;
    end
    if (acc) begin
      p_dig = upd_digits; p_dp = upd_dp; p_blank = upd_blank;
      m_pend = 1'b1;
    end
    m_t = en ? (m_t + 1) % FRAME : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("seg", 32'(SMG_Data), 32'(exp_seg));
    check("scan", 32'(Scan_Sig), 32'(exp_scan));
    check("frame_done", 32'(frame_done), 32'(exp_done));
    check("upd_ready", 32'(upd_ready), 32'(!m_pend));
  endtask

  task automatic new_frame();
    upd_digits = 24'($urandom);
    upd_dp     = 6'($urandom);
    upd_blank  = ($urandom_range(3) == 0) ? 6'($urandom) : 6'd0;
  endtask

  initial begin
    bit found;
    model_reset();
    repeat (3) step();
    rst = 1'b0;

    // Free-running scan with the cleared frame.
    en = 1'b1;
    repeat (120) step();

    // Directed frame from the digit-per-slot example.
    upd_digits = 24'h543210; upd_dp = 6'b000100; upd_blank = '0;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    repeat (110) step();

    // Blank mask example.
    upd_digits = 24'h888888; upd_dp = '0; upd_blank = 6'b100001;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    repeat (110) step();

    // Offer a frame exactly on the boundary cycle.
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (!m_pend && (m_t % FRAME == FRAME - 1)) found = 1'b1;
      else step();
    end
    check("boundary_wait_timeout", 32'(found), 32'd1);
    upd_digits = 24'hABCDEF; upd_dp = 6'b101010; upd_blank = '0;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    repeat (110) step();

    // Drop enable with a frame pending, then restart.
    upd_digits = 24'h13579B; upd_dp = 6'b000001; upd_valid = 1'b1;
    repeat (5) step();
    upd_valid = 1'b0;
    step();
    en = 1'b0;
    repeat (4) step();
    en = 1'b1;
    repeat (60) step();

    // Randomized traffic with occasional enable toggles.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299) == 0) en = ~en;
      else if (!en && $urandom_range(7) == 0) en = 1'b1;
      if (!upd_valid || last_acc) begin
        upd_valid = ($urandom_range(15) == 0);
        new_frame();
      end
      step();
    end
    upd_valid = 1'b0;
    en = 1'b1;
    repeat (60) step();

    // Asynchronous reset mid-slot while digit 3 is lit.
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if ((m_t / DC) % 6 == 3 && (m_t % DC) == 5) found = 1'b1;
      else step();
    end
    check("digit3_wait_timeout", 32'(found), 32'd1);
    step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", 32'(SMG_Data), 32'hFF);
    check("async_rst_scan", 32'(Scan_Sig), 32'h3F);
    check("async_rst_ready", 32'(upd_ready), 32'd1);
    check("async_rst_done", 32'(frame_done), 32'd0);
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    repeat (100) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
